fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Read-side engine for the team's synchronous FIFO. On a start pulse it drains exactly `len` words from the FIFO and presents them on a valid/ready output stream, marking the final word with `m_last`. It absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer, so it sustains one word per cycle under continuous `m_ready`. It sits between the FIFO's `r_en`/`data_out`/`empty` port and any downstream stream consumer.

## Interface
- `DATA_WIDTH`, default 8: FIFO word and stream data width.
- `LEN_WIDTH`, default 8: width of the burst length; max burst is 2^LEN_WIDTH-1 words.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle burst request; sampled only in IDLE.
- `len`  in  LEN_WIDTH  number of words in the burst; sampled with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle after `done`.
- `done`  out  1  one-cycle pulse when the burst completes.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_r_en`  out  1  FIFO read enable.
- `fifo_data`  in  DATA_WIDTH  FIFO read data, valid the cycle after `fifo_r_en`.
- `m_valid`  out  1  stream data valid.
- `m_data`  out  DATA_WIDTH  stream data, taken from the buffer head.
- `m_last`  out  1  high with the final word of the burst.
- `m_ready`  in  1  stream consumer ready.

## Operation
- States:
  - IDLE: waits for `start`.
  - ACTIVE: issues reads while `remaining > 0`.
  - DRAIN: all reads are issued; waits for in-flight and buffered words to be accepted.
  - DONE: one cycle, asserts `done`, returns to IDLE.
- IDLE transitions:
  - `start` with `len != 0` -> ACTIVE; `remaining` loads `len`.
  - `start` with `len == 0` -> DONE directly; no FIFO reads and no stream beats.
- `start` is ignored in every state other than IDLE.
- `fifo_r_en` = ACTIVE & `remaining != 0` & !`fifo_empty` & (`occ` + `inflight` < 2 | (`occ` + `inflight` == 2 & pop)).
  - `occ` is buffer occupancy (0..2).
  - `inflight` is the registered value of `fifo_r_en` from the previous cycle.
  - pop = `m_valid` & `m_ready`.
  - `fifo_r_en` is never asserted while `fifo_empty` = 1; the block does not rely on the FIFO's internal guard.
- Each issued read decrements `remaining`. ACTIVE -> DRAIN on the edge where `remaining` reaches 0.
- When `inflight` = 1, `fifo_data` is written into the buffer tail at the end of that cycle.
- Buffer: 2-entry FIFO with head/tail index and `occ` counter. Push and pop in the same cycle leave `occ` unchanged. Overflow cannot occur by construction; the bench checks it with an assertion.
- `m_valid` = (`occ` != 0). `m_data` = head entry.
- `m_data` and `m_valid` stay stable while `m_valid` & !`m_ready`.
- `m_last` = `m_valid` & (head word is the burst's final word). Track this with a delivered-word counter compared to the latched `len`.
- DRAIN -> DONE on the pop of the `m_last` word. DONE -> IDLE on the next edge.
- Stalls:
  - `fifo_empty` mid-burst: reads pause and the burst resumes when the FIFO refills. There is no timeout.
  - `m_ready` low: reads stop once `occ` + `inflight` = 2. No word is lost or duplicated.
- Reset mid-burst: state returns to IDLE, buffer and counters clear, and any in-flight FIFO word is discarded. The system resets the FIFO together with this block.

## Timing
- Reset values: `fifo_r_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0, `occ`=0, `remaining`=0.
- `start` is accepted at edge E0, with the FIFO non-empty and `m_ready`=1:
  - `fifo_r_en`=1 in cycle 1.
  - FIFO `data_out` updates at E1.
  - `fifo_data` is captured at E2.
  - `m_valid`=1 in cycle 3.
- Throughput: one word per cycle under continuous `m_ready` and a non-empty FIFO.
- `done` is asserted in the cycle after the `m_last` beat is accepted. `busy` falls in the following cycle.
- A new `start` is accepted no earlier than the cycle after `done`.

## Test plan
- Basic burst: FIFO preloaded with 0x11..0x15, `start` with `len`=5, `m_ready`=1 -> `m_data` 0x11..0x15 on five consecutive cycles starting 3 cycles after `start`; `m_last` only on 0x15; `done` one cycle later; 5 `fifo_r_en` pulses total.
- Backpressure: `len`=4, `m_ready` toggling 1,0,0,1,... -> in-order 4-word sequence; at most 2 reads outstanding beyond accepted beats; no `fifo_r_en` while the buffer plus in-flight count is full and no pop occurs.
- Empty stall: FIFO holds 2 words, `len`=4; push 2 more words 10 cycles later -> `fifo_r_en` never high while `fifo_empty`=1; all 4 words delivered; `done` after the 4th.
- Zero length: `start` with `len`=0 -> `done` next cycle; `fifo_r_en` and `m_valid` stay 0.
- Start while busy: second `start` mid-burst -> ignored; word count equals the first `len` only.
- Reset mid-burst: `rst_n`=0 after 2 of 6 words -> all outputs at reset values on the next cycle; a fresh `len`=3 burst after reset delivers correctly.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a len-word burst from a registered-read FIFO onto a valid/ready stream
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;
  state_t state, state_d;
  logic [LEN_WIDTH-1:0] remaining, len_q, delivered;
  logic [DATA_WIDTH-1:0] mem [2];
  logic [1:0] occ, pend;
  logic head, tail, inflight, pop;
  assign pop = m_valid & m_ready;
  assign pend = occ + {1'b0, inflight};
  // a read may be issued into a full slot only if a word leaves the buffer this cycle
  assign fifo_r_en = state == ACTIVE && remaining != '0 && !fifo_empty &&
                     (pend < 2'd2 || (pend == 2'd2 && pop));
  assign m_valid = occ != 2'd0;
  assign m_data = mem[head];
  assign m_last = m_valid && delivered == len_q - LEN_WIDTH'(1);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_comb begin
    state_d = state;
    if (state == IDLE && start) state_d = len != '0 ? ACTIVE : DONE;
    if (state == ACTIVE && fifo_r_en && remaining == LEN_WIDTH'(1)) state_d = DRAIN;
    if (state == DRAIN && pop && m_last) state_d = DONE;
    if (state == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining <= '0;
      len_q <= '0;
      delivered <= '0;
      occ <= '0;
      head <= 1'b0;
      tail <= 1'b0;
      inflight <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      inflight <= fifo_r_en;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
      if (pop) begin
        head <= ~head;
        delivered <= delivered + LEN_WIDTH'(1);
      end
      if (inflight) begin
        mem[tail] <= fifo_data;
        tail <= ~tail;
      end
      if (state == IDLE && start) begin
        remaining <= len;
        len_q <= len;
        delivered <= '0;
      end else if (fifo_r_en) remaining <= remaining - LEN_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed and random bursts against a FIFO model and a transaction scoreboard
module tb_fifo_burst_reader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, fifo_empty = 1'b1, m_ready = 1'b1, push_en = 1'b0;
  logic [7:0] len = '0, fifo_data = '0, push_data = '0, tmp;
  logic fifo_r_en, m_valid, m_last, busy, done;
  logic [7:0] m_data;
  logic [7:0] fq[$], rf[$];
  int checks = 0, errors = 0;
  int eb = 0, ed = 0, bl = 0, k = 0, rd = 0, stall = 0;
  logic [7:0] pd = '0;
  int b, f, d, ln, pre;
  typedef struct { int ln, pre, base, beats, first, dn; } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  fifo_burst_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy), .done(done),
    .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en), .fifo_data(fifo_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  // registered-read FIFO: data_out updates on the edge that sees r_en
  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete();
      fifo_data <= '0;
    end else begin
      if (fifo_r_en && fq.size() != 0) begin
        tmp = fq.pop_front();
        fifo_data <= tmp;
      end
      if (push_en) fq.push_back(push_data);
    end
    fifo_empty <= fq.size() == 0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // transaction model: a burst of L owes the next L pushed words in order, then done, then idle
  always @(negedge clk) begin
    if (!rst_n) begin
      eb = 0; ed = 0; k = 0; rd = 0; stall = 0;
      rf.delete();
    end else begin
      chk("busy", int'(busy), eb);
      chk("done", int'(done), ed);
      chk("rd_while_empty", int'(fifo_r_en & fifo_empty), 0);
      if (eb == 0) chk("idle_quiet", int'(m_valid | fifo_r_en), 0);
      assert ({1'b0, dut.occ} + {2'b0, dut.inflight} <= 3'd2) else begin
        errors++;
        $display("FAIL overflow: occ %0d inflight %0d", dut.occ, dut.inflight);
      end
      if (stall != 0) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), int'(pd));
      end
      stall = int'(m_valid & !m_ready);
      pd = m_data;
      if (fifo_r_en) rd++;
      if (m_valid && m_ready) begin
        if (rf.size() == 0) chk("beat_extra", 1, 0);
        else begin
          chk("beat_data", int'(m_data), int'(rf[0]));
          tmp = rf.pop_front();
        end
        chk("beat_last", int'(m_last), int'(k == bl - 1));
        k++;
      end
      chk("outstanding", int'(rd - k > 2), 0);
      if (ed != 0) begin
        ed = 0; eb = 0;
      end else if (eb == 0) begin
        if (start) begin
          eb = 1; bl = int'(len); k = 0; rd = 0; ed = int'(len == 0);
        end
      end else if (m_valid && m_ready && k == bl) begin
        ed = 1;
        chk("reads", rd, bl);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    push_en = 1'b1;
    push_data = w;
    rf.push_back(w);
    tick;
    push_en = 1'b0;
  endtask

  task automatic run_burst(input int bln, input int bpre, input int base, input int bp,
                           input int late_at, input int late_n, input int stop_at,
                           input int restart_at, output int beats, output int first_v,
                           output int done_cyc);
    beats = 0; first_v = 0; done_cyc = 0;
    tick;
    for (int i = 0; i < bpre; i++) push_word(base < 0 ? 8'($urandom) : 8'(base + i));
    start = 1'b1;
    len = 8'(bln);
    tick;
    start = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (m_valid && first_v == 0) first_v = n;
      if (m_valid && m_ready) beats++;
      if (done) begin
        done_cyc = n;
        break;
      end
      if (beats == stop_at) break;
      tick;
      m_ready = bp == 0 ? 1'b1 : bp == 1 ? (n % 3 == 0) : 1'($urandom_range(0, 1));
      start = n + 1 == restart_at;
      if (start) len = 8'd3;
      push_en = n + 1 >= late_at && n + 1 < late_at + late_n;
      if (push_en) begin
        push_data = 8'($urandom);
        rf.push_back(push_data);
      end
    end
    m_ready = 1'b1;
    start = 1'b0;
    push_en = 1'b0;
    if (done_cyc == 0 && stop_at < 0) chk("timeout", 0, 1);
  endtask

  initial begin
    vt[0] = '{5, 5, 'h11, 5, 3, 8};
    vt[1] = '{1, 1, -1, 1, 3, 4};
    vt[2] = '{0, 0, -1, 0, 0, 1};
    vt[3] = '{4, 6, -1, 4, 3, 7};
    vt[4] = '{2, 0, -1, 2, 3, 5};
    vt[5] = '{3, 3, -1, 3, 3, 6};
    repeat (3) tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_r_en", int'(fifo_r_en), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_last", int'(m_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_occ", int'(dut.occ), 0);
    chk("rst_remaining", int'(dut.remaining), 0);
    for (int i = 0; i < 6; i++) begin
      run_burst(vt[i].ln, vt[i].pre, vt[i].base, 0, 0, 0, -1, 0, b, f, d);
      chk($sformatf("vec%0d_beats", i), b, vt[i].beats);
      chk($sformatf("vec%0d_first", i), f, vt[i].first);
      chk($sformatf("vec%0d_done", i), d, vt[i].dn);
    end
    run_burst(4, 4, -1, 1, 0, 0, -1, 0, b, f, d);
    chk("bp_pattern_beats", b, 4);
    run_burst(7, 7, -1, 2, 0, 0, -1, 0, b, f, d);
    chk("bp_random_beats", b, 7);
    run_burst(4, 2, -1, 0, 10, 2, -1, 0, b, f, d);
    chk("stall_beats", b, 4);
    chk("stall_done_late", int'(d > 11), 1);
    run_burst(6, 6, -1, 0, 0, 0, -1, 4, b, f, d);
    chk("restart_beats", b, 6);
    chk("restart_done", d, 9);
    run_burst(6, 6, -1, 0, 0, 0, 2, 0, b, f, d);
    chk("rst_mid_beats", b, 2);
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_r_en", int'(fifo_r_en), 0);
    chk("rst_mid_valid", int'(m_valid), 0);
    chk("rst_mid_data", int'(m_data), 0);
    chk("rst_mid_last", int'(m_last), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    run_burst(3, 3, -1, 0, 0, 0, -1, 0, b, f, d);
    chk("post_rst_beats", b, 3);
    chk("post_rst_done", d, 6);
    for (int r = 0; r < 25; r++) begin
      ln = $urandom_range(0, 12);
      pre = $urandom_range(0, ln);
      run_burst(ln, pre, -1, 2, $urandom_range(2, 15), ln - pre, -1, $urandom_range(0, 8), b, f, d);
      chk($sformatf("rand%0d_beats", r), b, ln);
    end
    repeat (3) tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
